alu_op_scheduler: RTL and testbench
===================================

# alu_op_scheduler

Arbitrates two requesters (switch-panel front end and sequenced test-vector engine) onto one shared multi-cycle signed ALU. Accepts one operation at a time with round-robin fairness, issues it with a start/done handshake, and returns the tagged result and status flags to the originator. Divide-by-zero is screened before issue so the ALU never sees it. Sits between the input front ends and the ALU, upstream of the display/LED result path.

## Interface
- OPER_W, 6: signed operand width (A, B)
- RESULT_W, 16: result width
- TIMEOUT, 255: max cycles from alu_start to alu_done (watchdog only)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid (bit n = requester n)
- req_ready  out  2  per-requester accept; transfer when valid&ready
- req_cmd  in  2x3  per-requester cmd: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 shr, 110 shl, 111 fact
- req_a, req_b  in  2xOPER_W  per-requester signed operands
- resp_valid  out  1  response valid, held until resp_ready
- resp_ready  in  1  response consumer ready
- resp_id  out  1  requester that owns the response
- resp_result  out  RESULT_W  result
- resp_flags  out  3  {overflow, error, negative}
- alu_start  out  1  one-cycle issue pulse
- alu_cmd, alu_a, alu_b  out  3/OPER_W/OPER_W  registered operands, stable from alu_start until alu_done
- alu_done  in  1  ALU completion pulse
- alu_result  in  RESULT_W; alu_flags  in  3  sampled on alu_done

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = one-hot grant, combinational: only one valid -> grant it; both valid -> grant rr_ptr. Transfer latches cmd/A/B and id, flips rr_ptr to the non-granted requester. Next: div (011) with B==0 -> RESP with result 0, flags 010; else ISSUE.
- ISSUE: alu_start=1 for one cycle -> WAIT.
- WAIT: alu_done -> capture alu_result/alu_flags, -> RESP. alu_done is ignored in every other state.
- RESP: resp_valid=1, data stable; resp_valid&resp_ready -> IDLE. No new request accepted before that.
- req_ready is 0 in all states except IDLE.
- Reset (any time, incl. mid-operation): state IDLE, rr_ptr=0, all outputs 0 (req_ready then follows req_valid combinationally); in-flight ALU result discarded.

## Timing
- Accept at cycle 0; alu_start at cycle 1; alu_done earliest cycle 2; resp_valid the cycle after alu_done (minimum 3 cycles accept->resp_valid).
- Div-by-zero: resp_valid at cycle 1, alu_start never asserted.
- Back-to-back: response handshake at cycle t -> earliest next accept at t+1.
- rr_ptr updates only on a transfer; a lone requester is served every turn without waiting on the idle one.
- Requester must hold valid and operands stable until ready; dropping valid before ready is legal and cancels the request.

## Configuration
- ALU_SCHED_TIMEOUT_EN defined: WAIT counts cycles from alu_start; if TIMEOUT cycles pass without alu_done -> RESP with result 0, flags 010; a late alu_done is ignored. Counter clears on reset and on entering ISSUE.
- Undefined: no counter; WAIT holds indefinitely until alu_done.

## Test plan
- Reset: rst=1 mid-WAIT -> same cycle resp_valid=0, alu_start=0; after release only req_valid=01 -> req_ready=01.
- Single op: requester 0 add A=5, B=-3, ALU done 2 cycles after start with 2 -> alu_start at cycle 1, resp_valid at cycle 4, resp_id=0, result 0x0002, flags 000.
- Fairness: both requesters valid continuously for 4 ops -> grants 0,1,0,1; never two consecutive grants to one while the other waits.
- Div-by-zero: requester 1 cmd 011, A=12, B=0 -> no alu_start, resp_valid at cycle 1, resp_id=1, result 0, flags 010.
- Backpressure: resp_ready=0 for 10 cycles -> resp_valid and data held, req_ready=00 throughout; accept one cycle after the handshake.
- With ALU_SCHED_TIMEOUT_EN, TIMEOUT=8, alu_done never pulsed -> resp flags 010, result 0 at cycle 10; later alu_done produces no response.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler that shares one multi-cycle signed ALU between two requesters.
// Optional ALU wait watchdog is enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_op_scheduler #(
    parameter int OPER_W   = 6,
    parameter int RESULT_W = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
    // The producer holds valid and payload stable until then; dropping valid early cancels.
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][2:0]        req_cmd,
    input  logic [1:0][OPER_W-1:0] req_a,
    input  logic [1:0][OPER_W-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic [RESULT_W-1:0]    resp_result,
    output logic [2:0]             resp_flags,
    output logic                   alu_start,
    output logic [2:0]             alu_cmd,
    output logic [OPER_W-1:0]      alu_a,
    output logic [OPER_W-1:0]      alu_b,
    input  logic                   alu_done,
    input  logic [RESULT_W-1:0]    alu_result,
    input  logic [2:0]             alu_flags,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_d;
    logic   rr_ptr;
    logic   grant_id;
    logic   accept;
    logic   div_zero;
    logic   timed_out;

    assign dbg_state = state;

    // A lone requester wins outright; rr_ptr only breaks ties.
    always_comb begin
        case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = rr_ptr;
            default: grant_id = 1'b0;
        endcase
    end

    assign div_zero = (req_cmd[grant_id] == 3'b011) && (req_b[grant_id] == '0);

    always_comb begin
        state_d    = state;
        req_ready  = 2'b00;
        accept     = 1'b0;
        alu_start  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_d   = div_zero ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (alu_done || timed_out) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            alu_cmd     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                rr_ptr  <= ~grant_id;
                alu_cmd <= req_cmd[grant_id];
                alu_a   <= req_a[grant_id];
                alu_b   <= req_b[grant_id];
                resp_id <= grant_id;
                if (div_zero) begin
                    resp_result <= '0;
                    resp_flags  <= 3'b010;
                end
            end
            // Completion is only meaningful while waiting; elsewhere alu_done is ignored.
            if (state == WAIT) begin
                if (alu_done) begin
                    resp_result <= alu_result;
                    resp_flags  <= alu_flags;
                end else if (timed_out) begin
                    resp_result <= '0;
                    resp_flags  <= 3'b010;
                end
            end
        end
    end

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts cycles since alu_start; leaving WAIT at TIMEOUT keeps it from wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == ISSUE || state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scenario bench for alu_op_scheduler: the bench plays both requesters and the ALU,
// and scoreboards every response against what it asked the ALU to return.
module tb_alu_op_scheduler;
    localparam int OPER_W   = 6;
    localparam int RESULT_W = 16;
    localparam int TIMEOUT  = 8;
    localparam int EW       = 1 + RESULT_W + 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][2:0]        req_cmd;
    logic [1:0][OPER_W-1:0] req_a;
    logic [1:0][OPER_W-1:0] req_b;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_id;
    logic [RESULT_W-1:0]    resp_result;
    logic [2:0]             resp_flags;
    logic                   alu_start;
    logic [2:0]             alu_cmd;
    logic [OPER_W-1:0]      alu_a;
    logic [OPER_W-1:0]      alu_b;
    logic                   alu_done;
    logic [RESULT_W-1:0]    alu_result;
    logic [2:0]             alu_flags;
    logic [1:0]             dbg_state;

    int            n_vec = 0;
    int            n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;

    alu_op_scheduler #(.OPER_W(OPER_W), .RESULT_W(RESULT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .alu_start(alu_start), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = 2'b00;
        req_cmd    = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        alu_done   = 1'b0;
        alu_result = '0;
        alu_flags  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int n, input logic [2:0] cmd,
                             input logic [OPER_W-1:0] a, input logic [OPER_W-1:0] b);
        req_cmd[n] = cmd;
        req_a[n]   = a;
        req_b[n]   = b;
    endtask

    function automatic logic [EW-1:0] got_resp();
        return {resp_id, resp_result, resp_flags};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        settle();
        n_vec++;
        if ({resp_valid, alu_start, req_ready, resp_result, resp_flags} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rv=%b st=%b rdy=%b res=%h fl=%b, want all 0",
                     resp_valid, alu_start, req_ready, resp_result, resp_flags);
        end
        tick();
        rst = 1'b0;
        // Start an op from requester 0 and reset it while waiting on the ALU.
        req_valid = 2'b01;
        drive_req(0, 3'b000, 6'd1, 6'd1);
        tick();
        req_valid = 2'b00;
        tick();
        n_vec++;
        if (dbg_state !== 2'd2) begin
            n_err++;
            $display("FAIL reset_reach_wait: state got %0d want 2", dbg_state);
        end
        rst = 1'b1;
        settle();
        n_vec++;
        if ({resp_valid, alu_start, dbg_state} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_wait: rv=%b st=%b state=%0d want 0/0/0",
                     resp_valid, alu_start, dbg_state);
        end
        tick();
        rst = 1'b0;
        // A late completion for the discarded op must not produce a response.
        alu_done   = 1'b1;
        alu_result = 16'h1234;
        tick();
        alu_done = 1'b0;
        settle();
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_discard: resp_valid got %b want 0", resp_valid);
        end
        req_valid = 2'b11;
        settle();
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL reset_rr_ptr: req_ready got %b want 01", req_ready);
        end
        req_valid = 2'b01;
        settle();
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL reset_lone: req_ready got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_single_op();
        req_valid = 2'b01;
        drive_req(0, 3'b000, 6'd5, 6'b111101);
        settle();
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL single_accept: req_ready got %b want 01", req_ready);
        end
        exp_q.push_back({1'b0, 16'h0002, 3'b000});
        tick();                                   // cycle 1
        req_valid = 2'b00;
        settle();
        n_vec++;
        if ({alu_start, alu_cmd, alu_a, alu_b, req_ready} !== {1'b1, 3'b000, 6'd5, 6'b111101, 2'b00}) begin
            n_err++;
            $display("FAIL single_issue: st=%b cmd=%b a=%h b=%h rdy=%b want 1/000/05/3d/00",
                     alu_start, alu_cmd, alu_a, alu_b, req_ready);
        end
        tick();                                   // cycle 2
        n_vec++;
        if (alu_start !== 1'b0) begin
            n_err++;
            $display("FAIL single_start_pulse: alu_start got %b want 0", alu_start);
        end
        tick();                                   // cycle 3
        alu_done   = 1'b1;
        alu_result = 16'h0002;
        alu_flags  = 3'b000;
        settle();
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_resp: resp_valid got %b want 0", resp_valid);
        end
        tick();                                   // cycle 4
        alu_done   = 1'b0;
        alu_result = 16'hdead;
        settle();
        n_vec++;
        exp_e = exp_q.pop_front();
        if (resp_valid !== 1'b1 || got_resp() !== exp_e) begin
            n_err++;
            $display("FAIL single_resp: rv=%b resp=%h want rv=1 resp=%h", resp_valid, got_resp(), exp_e);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        settle();
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_resp_drop: resp_valid got %b want 0", resp_valid);
        end
    endtask

    task automatic test_fairness();
        logic                model_rr;
        logic [1:0]          prev_ready;
        logic [2:0]          e_cmd;
        logic [OPER_W-1:0]   e_a;
        logic [RESULT_W-1:0] r;
        logic [2:0]          f;
        do_reset();
        model_rr   = 1'b0;
        prev_ready = 2'b00;
        for (int n = 0; n < 2; n++)
            drive_req(n, 3'($urandom_range(0, 2)), 6'($urandom_range(0, 63)), 6'($urandom_range(1, 63)));
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_vec++;
            if (req_ready !== (model_rr ? 2'b10 : 2'b01) || req_ready === prev_ready) begin
                n_err++;
                $display("FAIL fair_grant%0d: req_ready got %b want %b (prev %b)",
                         i, req_ready, model_rr ? 2'b10 : 2'b01, prev_ready);
            end
            prev_ready = req_ready;
            e_cmd = req_cmd[model_rr];
            e_a   = req_a[model_rr];
            r     = 16'($urandom_range(0, 65535));
            f     = 3'($urandom_range(0, 7));
            exp_q.push_back({model_rr, r, f});
            tick();                               // ISSUE
            drive_req(int'(model_rr), 3'($urandom_range(0, 2)),
                      6'($urandom_range(0, 63)), 6'($urandom_range(1, 63)));
            model_rr = ~model_rr;
            settle();
            n_vec++;
            if ({alu_start, alu_cmd, alu_a, req_ready} !== {1'b1, e_cmd, e_a, 2'b00}) begin
                n_err++;
                $display("FAIL fair_issue%0d: st=%b cmd=%b a=%h rdy=%b want 1/%b/%h/00",
                         i, alu_start, alu_cmd, alu_a, req_ready, e_cmd, e_a);
            end
            tick();                               // WAIT, earliest done
            alu_done   = 1'b1;
            alu_result = r;
            alu_flags  = f;
            tick();                               // RESP
            alu_done = 1'b0;
            settle();
            n_vec++;
            exp_e = exp_q.pop_front();
            if (resp_valid !== 1'b1 || got_resp() !== exp_e) begin
                n_err++;
                $display("FAIL fair_resp%0d: rv=%b resp=%h want rv=1 resp=%h", i, resp_valid, got_resp(), exp_e);
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_div_zero();
        req_valid = 2'b10;
        drive_req(1, 3'b011, 6'd12, 6'd0);
        // Requester 1 stays valid: each handshake must be followed by an accept one cycle later.
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++;
            if (req_ready !== 2'b10) begin
                n_err++;
                $display("FAIL dz_accept%0d: req_ready got %b want 10", i, req_ready);
            end
            exp_q.push_back({1'b1, 16'h0000, 3'b010});
            tick();
            settle();
            n_vec++;
            exp_e = exp_q.pop_front();
            if (alu_start !== 1'b0 || resp_valid !== 1'b1 || got_resp() !== exp_e) begin
                n_err++;
                $display("FAIL dz_resp%0d: st=%b rv=%b resp=%h want st=0 rv=1 resp=%h",
                         i, alu_start, resp_valid, got_resp(), exp_e);
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
        // Divisor of 1 is a normal operation and must reach the ALU.
        req_b[1] = 6'd1;
        settle();
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL div1_accept: req_ready got %b want 10", req_ready);
        end
        exp_q.push_back({1'b1, 16'd12, 3'b000});
        tick();
        req_valid = 2'b00;
        settle();
        n_vec++;
        if ({alu_start, resp_valid, alu_cmd, alu_b} !== {1'b1, 1'b0, 3'b011, 6'd1}) begin
            n_err++;
            $display("FAIL div1_issue: st=%b rv=%b cmd=%b b=%h want 1/0/011/01",
                     alu_start, resp_valid, alu_cmd, alu_b);
        end
        tick();
        alu_done   = 1'b1;
        alu_result = 16'd12;
        alu_flags  = 3'b000;
        tick();
        alu_done = 1'b0;
        settle();
        n_vec++;
        exp_e = exp_q.pop_front();
        if (resp_valid !== 1'b1 || got_resp() !== exp_e) begin
            n_err++;
            $display("FAIL div1_resp: rv=%b resp=%h want rv=1 resp=%h", resp_valid, got_resp(), exp_e);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [RESULT_W-1:0] r;
        logic [1:0]          want_next;
        r = 16'($urandom_range(0, 65535));
        req_valid = 2'b01;
        drive_req(0, 3'b010, 6'd7, 6'd9);
        drive_req(1, 3'b001, 6'd3, 6'd2);
        settle();
        want_next = (req_ready == 2'b01) ? 2'b10 : 2'b01;
        exp_q.push_back({1'b0, r, 3'b001});
        tick();
        req_valid = 2'b11;
        tick();
        alu_done   = 1'b1;
        alu_result = r;
        alu_flags  = 3'b001;
        tick();
        alu_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                alu_done   = 1'b1;
                alu_result = ~r;
                alu_flags  = 3'b110;
            end else begin
                alu_done = 1'b0;
            end
            settle();
            n_vec++;
            if (resp_valid !== 1'b1 || req_ready !== 2'b00 || got_resp() !== exp_q[0]) begin
                n_err++;
                $display("FAIL bp_hold%0d: rv=%b rdy=%b resp=%h want rv=1 rdy=00 resp=%h",
                         i, resp_valid, req_ready, got_resp(), exp_q[0]);
            end
            tick();
        end
        alu_done = 1'b0;
        exp_e = exp_q.pop_front();
        resp_ready = 1'b1;
        settle();
        n_vec++;
        if (resp_valid !== 1'b1 || got_resp() !== exp_e) begin
            n_err++;
            $display("FAIL bp_resp: rv=%b resp=%h want rv=1 resp=%h", resp_valid, got_resp(), exp_e);
        end
        tick();
        resp_ready = 1'b0;
        settle();
        n_vec++;
        if (req_ready !== want_next || want_next !== 2'b10) begin
            n_err++;
            $display("FAIL bp_next_accept: req_ready got %b want 10", req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

`ifdef ALU_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        req_valid = 2'b01;
        drive_req(0, 3'b111, 6'd4, 6'd0);
        exp_q.push_back({1'b0, 16'h0000, 3'b010});
        tick();                                   // cycle 1
        req_valid = 2'b00;
        for (int k = 1; k < 10; k++) begin
            settle();
            n_vec++;
            if (resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL to_early%0d: resp_valid got %b want 0", k, resp_valid);
            end
            tick();
        end
        settle();                                 // cycle 10
        n_vec++;
        exp_e = exp_q.pop_front();
        if (resp_valid !== 1'b1 || got_resp() !== exp_e) begin
            n_err++;
            $display("FAIL to_resp: rv=%b resp=%h want rv=1 resp=%h", resp_valid, got_resp(), exp_e);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        alu_done   = 1'b1;
        alu_result = 16'h00aa;
        tick();
        alu_done = 1'b0;
        settle();
        n_vec++;
        if (resp_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL to_late_done: rv=%b state=%0d want 0/0", resp_valid, dbg_state);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_div_zero();
        test_backpressure();
`ifdef ALU_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
